fp16_divider: RTL and testbench

Iterative half-precision floating-point divider (q = x / y), the inverse operation of the team's combinational fp16 multiplier in the fma16 exercise datapath. It uses restoring radix-2 mantissa division, one quotient bit per cycle, then a single rounding cycle. Operands and results move through valid/ready handshakes, and one operation is in flight at a time.

---
 rtl/fma16_pkg.sv | 32 +++
 rtl/fp16_div_round.sv | 81 ++++++++
 rtl/fp16_divider.sv | 186 ++++++++++++++++++
 tb/tb_fp16_divider.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 exercise datapath: rounding-mode
// encodings, binary16 special constants, exception-flag bit positions and
// the divider's control state type.
package fma16_pkg;

  // Rounding modes as carried on the 2-bit roundmode input.
  localparam logic [1:0] RM_RZ  = 2'b00;
  localparam logic [1:0] RM_RNE = 2'b01;
  localparam logic [1:0] RM_RM  = 2'b10;
  localparam logic [1:0] RM_RP  = 2'b11;

  // binary16 special encodings.
  localparam logic [15:0] POS_INF = 16'h7c00;
  localparam logic [15:0] NEG_INF = 16'hfc00;
  localparam logic [15:0] QNAN    = 16'h7e00;
  localparam logic [15:0] MAXNORM = 16'h7bff;

  // Bit positions within flags = {invalid, divzero, overflow, underflow, inexact}.
  localparam int unsigned FLG_INVALID   = 4;
  localparam int unsigned FLG_DIVZERO   = 3;
  localparam int unsigned FLG_OVERFLOW  = 2;
  localparam int unsigned FLG_UNDERFLOW = 1;
  localparam int unsigned FLG_INEXACT   = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_ROUND,
    S_DONE
  } div_state_e;

endpackage

// File: rtl/fp16_div_round.sv
// Combinational rounding / range stage of the fp16 divider.
// Takes the raw 12-bit quotient (1 integer, 10 fraction, 1 guard bit),
// the remainder-derived sticky bit and the pre-rounding biased exponent,
// and produces the final binary16 quotient plus exception flags.
//   i_sign      : sign of the quotient
//   i_e         : biased exponent before rounding, 7-bit two's complement
//   i_q         : quotient bits, i_q[11] is the hidden integer bit
//   i_sticky    : OR of the final division remainder
//   i_roundmode : RZ / RNE / RM / RP
//   o_result    : binary16 result (flush-to-zero on underflow)
//   o_flags     : {invalid, divzero, overflow, underflow, inexact}
module fp16_div_round
  import fma16_pkg::*;
(
  input  logic              i_sign,
  input  logic signed [6:0] i_e,
  input  logic [11:0]       i_q,
  input  logic              i_sticky,
  input  logic [1:0]        i_roundmode,
  output logic [15:0]       o_result,
  output logic [4:0]        o_flags
);

  logic              w_guard;
  logic              w_lsb;
  logic              w_gs;
  logic              w_inc;
  logic [11:0]       w_mant;
  logic              w_carry;
  logic [9:0]        w_frac;
  logic signed [6:0] w_e;

  always_comb begin
    w_guard = i_q[0];
    w_lsb   = i_q[1];
    w_gs    = w_guard | i_sticky;

    w_inc = 1'b0;
    case (i_roundmode)
      RM_RZ:  w_inc = 1'b0;
      RM_RNE: w_inc = w_guard & (w_lsb | i_sticky);
      RM_RM:  w_inc = i_sign & w_gs;
      RM_RP:  w_inc = ~i_sign & w_gs;
      default: w_inc = 1'b0;
    endcase

    w_mant = {1'b0, i_q[11:1]} + {11'd0, w_inc};
    // The hidden bit is always set on entry, so a carry to 2.0 shows up
    // as bit 11 set with bit 10 cleared.
    w_carry = w_mant[11] & ~w_mant[10];
    if (w_carry) begin
      w_frac = '0;
      w_e    = i_e + 7'sd1;
    end else begin
      w_frac = w_mant[9:0];
      w_e    = i_e;
    end

    o_result = '0;
    o_flags  = '0;
    if (w_e >= 7'sd31) begin
      o_flags[FLG_OVERFLOW] = 1'b1;
      o_flags[FLG_INEXACT]  = 1'b1;
      case (i_roundmode)
        RM_RNE:  o_result = i_sign ? NEG_INF : POS_INF;
        RM_RZ:   o_result = {i_sign, MAXNORM[14:0]};
        RM_RP:   o_result = i_sign ? {1'b1, MAXNORM[14:0]} : POS_INF;
        RM_RM:   o_result = i_sign ? NEG_INF : MAXNORM;
        default: o_result = i_sign ? NEG_INF : POS_INF;
      endcase
    end else if (w_e <= 7'sd0) begin
      o_result                = {i_sign, 15'd0};
      o_flags[FLG_UNDERFLOW] = 1'b1;
      o_flags[FLG_INEXACT]   = 1'b1;
    end else begin
      o_result             = {i_sign, w_e[4:0], w_frac};
      o_flags[FLG_INEXACT] = w_gs;
    end
  end

endmodule

// File: rtl/fp16_divider.sv
// Iterative binary16 divider, q = x / y.
// Restoring radix-2 mantissa division producing one quotient bit per cycle,
// followed by one rounding cycle. Special operands resolve at accept time and
// go straight to DONE. Subnormal inputs are treated as signed zero.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   x, y, roundmode      : dividend, divisor, rounding mode
//   out_valid / out_ready: result handshake (result held until accepted)
//   result, flags        : quotient, {invalid, divzero, overflow, underflow, inexact}
module fp16_divider
  import fma16_pkg::*;
#(
  parameter int unsigned QBITS = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [1:0]  roundmode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  localparam int unsigned CNT_W = $clog2(QBITS);

  div_state_e        r_state;
  div_state_e        w_state_nxt;

  logic              r_sign;
  logic [1:0]        r_rm;
  logic [10:0]       r_my;
  logic [11:0]       r_rem;
  logic [QBITS-1:0]  r_q;
  logic signed [6:0] r_e;
  logic [CNT_W-1:0]  r_cnt;
  logic [15:0]       r_result;
  logic [4:0]        r_flags;

  // Operand classification
  logic        w_sign;
  logic        w_x_zero, w_x_inf, w_x_nan;
  logic        w_y_zero, w_y_inf, w_y_nan;
  logic        w_special;
  logic [15:0] w_spec_result;
  logic [4:0]  w_spec_flags;
  logic [10:0] w_mx, w_my;
  logic        w_lt;
  logic [11:0] w_rem_init;
  logic signed [6:0] w_e_init;

  // Iteration datapath
  logic        w_ge;
  logic [11:0] w_diff;
  logic [11:0] w_sel;
  logic [11:0] w_rem_nxt;

  // Rounding stage
  logic [15:0] w_rnd_result;
  logic [4:0]  w_rnd_flags;

  always_comb begin
    w_sign   = x[15] ^ y[15];
    w_x_zero = (x[14:10] == 5'd0);
    w_x_inf  = (x[14:10] == 5'd31) && (x[9:0] == 10'd0);
    w_x_nan  = (x[14:10] == 5'd31) && (x[9:0] != 10'd0);
    w_y_zero = (y[14:10] == 5'd0);
    w_y_inf  = (y[14:10] == 5'd31) && (y[9:0] == 10'd0);
    w_y_nan  = (y[14:10] == 5'd31) && (y[9:0] != 10'd0);

    w_special     = 1'b1;
    w_spec_result = '0;
    w_spec_flags  = '0;
    if (w_x_nan || w_y_nan || (w_x_zero && w_y_zero) || (w_x_inf && w_y_inf)) begin
      w_spec_result              = QNAN;
      w_spec_flags[FLG_INVALID] = 1'b1;
    end else if (w_x_inf) begin
      w_spec_result = {w_sign, POS_INF[14:0]};
    end else if (w_y_zero) begin
      w_spec_result              = {w_sign, POS_INF[14:0]};
      w_spec_flags[FLG_DIVZERO] = 1'b1;
    end else if (w_x_zero || w_y_inf) begin
      w_spec_result = {w_sign, 15'd0};
    end else begin
      w_special = 1'b0;
    end

    w_mx       = {1'b1, x[9:0]};
    w_my       = {1'b1, y[9:0]};
    w_lt       = (w_mx < w_my);
    // Pre-shift a smaller dividend so the first quotient bit is always 1.
    w_rem_init = w_lt ? {w_mx, 1'b0} : {1'b0, w_mx};
    w_e_init   = 7'({2'b00, x[14:10]}) - 7'({2'b00, y[14:10]}) + 7'd15 - {6'd0, w_lt};

    w_ge      = (r_rem >= {1'b0, r_my});
    w_diff    = r_rem - {1'b0, r_my};
    w_sel     = w_ge ? w_diff : r_rem;
    w_rem_nxt = w_sel << 1;
  end

  fp16_div_round u_round (
    .i_sign      (r_sign),
    .i_e         (r_e),
    .i_q         (r_q),
    .i_sticky    (|r_rem),
    .i_roundmode (r_rm),
    .o_result    (w_rnd_result),
    .o_flags     (w_rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_special ? S_DONE : S_DIV;
      end
      S_DIV: begin
        if (r_cnt == CNT_W'(QBITS - 1)) w_state_nxt = S_ROUND;
      end
      S_ROUND: w_state_nxt = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sign   <= 1'b0;
      r_rm     <= '0;
      r_my     <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_e      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_rm   <= roundmode;
            r_cnt  <= '0;
            r_q    <= '0;
            if (w_special) begin
              r_result <= w_spec_result;
              r_flags  <= w_spec_flags;
            end else begin
              r_my  <= w_my;
              r_rem <= w_rem_init;
              r_e   <= w_e_init;
            end
          end
        end
        S_DIV: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QBITS-2:0], w_ge};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_ROUND: begin
          r_result <= w_rnd_result;
          r_flags  <= w_rnd_flags;
          r_cnt    <= '0;
        end
        S_DONE: ;
      endcase
    end
  end

  assign result = r_result;
  assign flags  = r_flags;

endmodule

// File: tb/tb_fp16_divider.sv
module tb_fp16_divider;
  import fma16_pkg::*;

  localparam int QB = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic [1:0]  roundmode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int total = 0;
  int bad   = 0;

  // Expected {flags, result} per accepted operation, oldest first.
  logic [20:0] exp_q[$];

  fp16_divider #(.QBITS(QB)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .roundmode (roundmode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit is_special(input logic [15:0] a, input logic [15:0] b);
    return (a[14:10] == 5'd0) || (a[14:10] == 5'd31) ||
           (b[14:10] == 5'd0) || (b[14:10] == 5'd31);
  endfunction

  // Reference: exact integer division of the significands, rounding decided
  // by comparing the true remainder with half an ulp.
  function automatic logic [20:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] rm);
    logic s;
    int ea, eb, ma, mb, num, sig, r, e;
    bit anan, bnan, ainf, binf, az, bz, up;
    s    = a[15] ^ b[15];
    ea   = int'(a[14:10]);
    eb   = int'(b[14:10]);
    az   = (ea == 0);
    bz   = (eb == 0);
    ainf = (ea == 31) && (a[9:0] == 0);
    binf = (eb == 31) && (b[9:0] == 0);
    anan = (ea == 31) && (a[9:0] != 0);
    bnan = (eb == 31) && (b[9:0] != 0);
    if (anan || bnan || (az && bz) || (ainf && binf)) return {5'b10000, 16'h7e00};
    if (ainf) return {5'b00000, s, 15'h7c00};
    if (bz)   return {5'b01000, s, 15'h7c00};
    if (az || binf) return {5'b00000, s, 15'h0000};
    ma  = 1024 + int'(a[9:0]);
    mb  = 1024 + int'(b[9:0]);
    num = ma * 1024;
    e   = ea - eb + 15;
    if (ma < mb) begin
      num = num * 2;
      e   = e - 1;
    end
    sig = num / mb;
    r   = num % mb;
    case (rm)
      2'b01:   up = (2 * r > mb) || ((2 * r == mb) && (sig % 2 == 1));
      2'b10:   up = s && (r != 0);
      2'b11:   up = !s && (r != 0);
      default: up = 1'b0;
    endcase
    if (up) sig = sig + 1;
    if (sig == 2048) begin
      sig = 1024;
      e   = e + 1;
    end
    if (e >= 31) begin
      case (rm)
        2'b01:   return {5'b00101, s, 15'h7c00};
        2'b00:   return {5'b00101, s, 15'h7bff};
        2'b11:   return {5'b00101, s ? 16'hfbff : 16'h7c00};
        default: return {5'b00101, s ? 16'hfc00 : 16'h7bff};
      endcase
    end
    if (e <= 0) return {5'b00011, s, 15'h0000};
    return {4'b0000, (r != 0), s, 5'(e), 10'(sig % 1024)};
  endfunction

  // Output checker: every cycle a result is presented it must match the
  // oldest outstanding expectation; it retires on the handshake.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out_valid: got out_valid=1 with result %h, required no result (t=%0t)",
                 result, $time);
      end else begin
        chk("result", 32'(result), 32'(exp_q[0][15:0]));
        chk("flags", 32'(flags), 32'(exp_q[0][20:16]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [1:0] rm,
                       input int hold, input bit use_lit, input logic [20:0] lit);
    int n;
    logic [20:0] m;
    m = model(a, b, rm);
    if (use_lit) chk("model_literal", 32'(m), 32'(lit));
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_before_op", 32'(in_ready), 32'd1);
    x         = a;
    y         = b;
    roundmode = rm;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    exp_q.push_back(m);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    x         = 16'($urandom);
    y         = 16'($urandom);
    roundmode = 2'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n + 1), is_special(a, b) ? 32'd1 : 32'(QB + 2));
    if (!out_valid) begin
      exp_q.delete();
      return;
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        x        = 16'($urandom);
        y        = 16'($urandom);
        @(posedge clk); #1;
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        chk("held_out_valid", 32'(out_valid), 32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("post_handshake_in_ready", 32'(in_ready), 32'd1);
    chk("post_handshake_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, b;
    int hold;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    x         = '0;
    y         = '0;
    roundmode = RM_RNE;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    reset = 1'b0;

    // Directed cases with hand-computed expectations.
    do_op(16'h3c00, 16'h3c00, RM_RNE, 0, 1'b1, {5'b00000, 16'h3c00});
    do_op(16'h4600, 16'h4200, RM_RNE, 0, 1'b1, {5'b00000, 16'h4000});
    do_op(16'h3c00, 16'h4200, RM_RNE, 0, 1'b1, {5'b00001, 16'h3555});
    do_op(16'h3c00, 16'h4200, RM_RZ,  0, 1'b1, {5'b00001, 16'h3555});
    do_op(16'h3c00, 16'h4200, RM_RP,  0, 1'b1, {5'b00001, 16'h3556});
    do_op(16'hbc00, 16'h4200, RM_RM,  0, 1'b1, {5'b00001, 16'hb556});
    do_op(16'h7bff, 16'h1400, RM_RNE, 0, 1'b1, {5'b00101, 16'h7c00});
    do_op(16'h7bff, 16'h1400, RM_RZ,  0, 1'b1, {5'b00101, 16'h7bff});
    do_op(16'h0400, 16'h7800, RM_RNE, 0, 1'b1, {5'b00011, 16'h0000});
    do_op(16'h3c00, 16'h0000, RM_RNE, 0, 1'b1, {5'b01000, 16'h7c00});
    do_op(16'h0000, 16'h0000, RM_RNE, 0, 1'b1, {5'b10000, 16'h7e00});
    do_op(16'h7c00, 16'h7c00, RM_RNE, 0, 1'b1, {5'b10000, 16'h7e00});
    do_op(16'h7e00, 16'h3c00, RM_RNE, 0, 1'b1, {5'b10000, 16'h7e00});

    // Backpressure: result held for 10 cycles while new requests are ignored.
    do_op(16'h4600, 16'h4200, RM_RNE, 10, 1'b1, {5'b00000, 16'h4000});

    // Reset in the fifth DIV cycle.
    x         = 16'h4600;
    y         = 16'h4200;
    roundmode = RM_RNE;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrun_reset_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_reset_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_reset_result", 32'(result), 32'd0);
    chk("midrun_reset_flags", 32'(flags), 32'd0);
    exp_q.delete();
    do_op(16'h4600, 16'h4200, RM_RNE, 0, 1'b1, {5'b00000, 16'h4000});

    // Randomized operations against the reference model.
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        a = 16'($urandom);
        b = 16'($urandom);
      end else begin
        a = {1'($urandom), 5'($urandom_range(30, 1)), 10'($urandom)};
        b = {1'($urandom), 5'($urandom_range(30, 1)), 10'($urandom)};
      end
      hold = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
      do_op(a, b, 2'($urandom), hold, 1'b0, '0);
    end

    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
